osc_reg_master: RTL and testbench



---
 rtl/osc_reg_master.sv | 197 +++++++++++++++++++
 tb/tb_osc_reg_master.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osc_reg_master.sv
// Register-bus initiator for the oscillator offset registers: buffers control-side
// commands, sequences them onto the synth register bus and bulk-inits every offset.
module osc_reg_master #(
   parameter int unsigned V_OSC      = 4,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned FIFO_AW    = 2
) (
   input  logic       reg_clk,
   input  logic       reset_reg,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_write,
   input  logic [6:0] cmd_adr,
   input  logic [7:0] cmd_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   input  logic       init_start,
   input  logic [7:0] init_value,
   output logic       init_busy,
   output logic [6:0] adr,
   output logic [7:0] bus_wdata,
   input  logic [7:0] bus_rdata,
   output logic       write,
   output logic       read,
   output logic       read_select,
   output logic       osc_sel
);
   localparam int unsigned CNT_W = FIFO_AW + 1;
   localparam int unsigned ENT_W = 16;
   localparam int unsigned OSC_W = 3;

   typedef enum logic [2:0] {
      S_IDLE, S_WR, S_RD_A, S_RD_B, S_GAP, S_INIT_WR, S_INIT_GAP
   } state_t;

   state_t             state_q, state_d;
   logic [ENT_W-1:0]   fifo_q [FIFO_DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               push, pop, full, empty;
   logic [ENT_W-1:0]   head;
   logic [6:0]         cur_adr_q, cur_adr_d;
   logic [7:0]         cur_data_q, cur_data_d;
   logic [7:0]         init_val_q, init_val_d;
   logic [OSC_W-1:0]   osc_q, osc_d;
   logic               rd_last_q, rd_last_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [7:0]         rsp_data_q, rsp_data_d;
   logic               init_busy_q, init_busy_d;
   logic [6:0]         adr_q, adr_d;
   logic [7:0]         wdata_q, wdata_d;
   logic               write_q, write_d, read_q, read_d;
   logic               rsel_q, rsel_d, osc_sel_q, osc_sel_d;

   // FIFO status and push handshake
   always_comb begin
      full      = (count_q == CNT_W'(FIFO_DEPTH));
      empty     = (count_q == '0);
      cmd_ready = !full && !reset_reg;
      push      = cmd_valid && cmd_ready;
      head      = fifo_q[rd_ptr_q];
   end

   // Next-state logic; bus outputs are registered from the current state so
   // every strobe lags its state by one cycle and nothing is combinational.
   always_comb begin
      state_d     = state_q;
      pop         = 1'b0;
      cur_adr_d   = cur_adr_q;
      cur_data_d  = cur_data_q;
      init_val_d  = init_val_q;
      osc_d       = osc_q;
      write_d     = 1'b0;
      read_d      = 1'b0;
      rsel_d      = 1'b0;
      osc_sel_d   = 1'b0;
      adr_d       = adr_q;
      wdata_d     = wdata_q;
      rd_last_d   = (state_q == S_RD_B);
      rsp_valid_d = rd_last_q;
      rsp_data_d  = rd_last_q ? bus_rdata : rsp_data_q;
      init_busy_d = (state_q == S_INIT_WR) || (state_q == S_INIT_GAP);

      case (state_q)
         S_IDLE: begin
            if (init_start) begin
               init_val_d = init_value;
               osc_d      = '0;
               state_d    = S_INIT_WR;
            end else if (!empty) begin
               pop        = 1'b1;
               cur_adr_d  = head[14:8];
               cur_data_d = head[7:0];
               state_d    = head[15] ? S_WR : S_RD_A;
            end
         end
         S_WR:      state_d = S_GAP;
         S_RD_A:    state_d = S_RD_B;
         S_RD_B:    state_d = S_GAP;
         S_GAP:     state_d = S_IDLE;
         S_INIT_WR: state_d = S_INIT_GAP;
         S_INIT_GAP: begin
            if (osc_q == OSC_W'(V_OSC - 1)) begin
               state_d = S_IDLE;
            end else begin
               osc_d   = osc_q + OSC_W'(1);
               state_d = S_INIT_WR;
            end
         end
         default:   state_d = S_IDLE;
      endcase

      case (state_q)
         S_WR: begin
            osc_sel_d = 1'b1;
            write_d   = 1'b1;
            adr_d     = cur_adr_q;
            wdata_d   = cur_data_q;
         end
         S_RD_A, S_RD_B: begin
            osc_sel_d = 1'b1;
            read_d    = 1'b1;
            rsel_d    = 1'b1;
            adr_d     = cur_adr_q;
         end
         S_INIT_WR: begin
            osc_sel_d = 1'b1;
            write_d   = 1'b1;
            adr_d     = {osc_q, 4'b0110};
            wdata_d   = init_val_q;
         end
         default: ;
      endcase

      wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   // Command storage; contents are don't-care until pushed
   always_ff @(posedge reg_clk) begin
      if (push) fifo_q[wr_ptr_q] <= {cmd_write, cmd_adr, cmd_data};
   end

   always_ff @(posedge reg_clk) begin
      if (reset_reg) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         cur_adr_q   <= '0;
         cur_data_q  <= '0;
         init_val_q  <= '0;
         osc_q       <= '0;
         rd_last_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         init_busy_q <= 1'b0;
         adr_q       <= '0;
         wdata_q     <= '0;
         write_q     <= 1'b0;
         read_q      <= 1'b0;
         rsel_q      <= 1'b0;
         osc_sel_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         cur_adr_q   <= cur_adr_d;
         cur_data_q  <= cur_data_d;
         init_val_q  <= init_val_d;
         osc_q       <= osc_d;
         rd_last_q   <= rd_last_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         init_busy_q <= init_busy_d;
         adr_q       <= adr_d;
         wdata_q     <= wdata_d;
         write_q     <= write_d;
         read_q      <= read_d;
         rsel_q      <= rsel_d;
         osc_sel_q   <= osc_sel_d;
      end
   end

   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = rsp_data_q;
   assign init_busy   = init_busy_q;
   assign adr         = adr_q;
   assign bus_wdata   = wdata_q;
   assign write       = write_q;
   assign read        = read_q;
   assign read_select = rsel_q;
   assign osc_sel     = osc_sel_q;

endmodule

// File: tb/tb_osc_reg_master.sv
// Bench for osc_reg_master: oscillator register-file slave, bus monitor and a
// command-level reference model (ordered transaction list plus register shadow).
module tb_osc_reg_master;
   localparam int unsigned V_OSC = 4;

   logic       reg_clk = 1'b0;
   logic       reset_reg = 1'b1;
   logic       cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
   logic [6:0] cmd_adr = '0;
   logic [7:0] cmd_data = '0;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       init_start = 1'b0;
   logic [7:0] init_value = '0;
   logic       init_busy;
   logic [6:0] adr;
   logic [7:0] bus_wdata;
   logic [7:0] bus_rdata = 8'h00;
   logic       write, read, read_select, osc_sel;

   osc_reg_master #(.V_OSC(V_OSC), .FIFO_DEPTH(4), .FIFO_AW(2)) dut (
      .reg_clk(reg_clk), .reset_reg(reset_reg),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_adr(cmd_adr), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .init_start(init_start), .init_value(init_value), .init_busy(init_busy),
      .adr(adr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
      .write(write), .read(read), .read_select(read_select), .osc_sel(osc_sel)
   );

   always #5 reg_clk = ~reg_clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge reg_clk) cyc <= cyc + 1;

   // Oscillator register file: captures writes on posedge, loads output on negedge of a read
   logic [7:0] slave_mem [128] = '{default: 8'h00};
   always @(posedge reg_clk) if (write === 1'b1 && osc_sel === 1'b1) slave_mem[adr] <= bus_wdata;
   always @(negedge reg_clk) if (read === 1'b1 && read_select === 1'b1 && osc_sel === 1'b1) bus_rdata <= slave_mem[adr];

   // Bus monitor
   logic [15:0] obs_bus[$];
   int          obs_cyc[$];
   logic [7:0]  obs_rsp[$];
   int          rsp_cyc[$];
   bit prev_rd = 0, prev_any = 0;
   int wr_run = 0, rd_run = 0, rsp_run = 0;
   int last_wr_len = 0, last_rd_len = 0, last_rsp_len = 0;
   int gap_viol = 0, strobe_bad = 0;
   always @(negedge reg_clk) begin
      if (write === 1'b1) begin obs_bus.push_back({1'b1, adr, bus_wdata}); obs_cyc.push_back(cyc); end
      if (read === 1'b1 && !prev_rd) begin obs_bus.push_back({1'b0, adr, 8'h00}); obs_cyc.push_back(cyc); end
      if ((write === 1'b1 || (read === 1'b1 && !prev_rd)) && prev_any) gap_viol++;
      if ((write === 1'b1 && (osc_sel !== 1'b1 || read !== 1'b0 || read_select !== 1'b0)) ||
          (read === 1'b1 && (osc_sel !== 1'b1 || read_select !== 1'b1))) strobe_bad++;
      if (rsp_valid === 1'b1) begin obs_rsp.push_back(rsp_data); rsp_cyc.push_back(cyc); end
      if (write === 1'b1) wr_run++; else if (wr_run != 0) begin last_wr_len = wr_run; wr_run = 0; end
      if (read === 1'b1) rd_run++; else if (rd_run != 0) begin last_rd_len = rd_run; rd_run = 0; end
      if (rsp_valid === 1'b1) rsp_run++; else if (rsp_run != 0) begin last_rsp_len = rsp_run; rsp_run = 0; end
      prev_rd  = (read === 1'b1);
      prev_any = (write === 1'b1) || (read === 1'b1) || (osc_sel === 1'b1);
   end

   // Reference model: ordered bus transactions and the register contents they imply
   logic [7:0]  shadow [128] = '{default: 8'h00};
   logic [15:0] exp_bus[$];
   logic [7:0]  exp_rsp[$];

   function automatic void model_write(input logic [6:0] a, input logic [7:0] d);
      exp_bus.push_back({1'b1, a, d});
      shadow[a] = d;
   endfunction

   function automatic void model_read(input logic [6:0] a);
      exp_bus.push_back({1'b0, a, 8'h00});
      exp_rsp.push_back(shadow[a]);
   endfunction

   function automatic void model_init(input logic [7:0] v);
      for (int o = 0; o < int'(V_OSC); o++) model_write(7'(6 + 16 * o), v);
   endfunction

   task automatic clear_logs();
      obs_bus.delete(); obs_cyc.delete(); obs_rsp.delete(); rsp_cyc.delete();
      exp_bus.delete(); exp_rsp.delete();
   endtask

   // Called at a negedge; returns at the negedge after the accepting posedge
   task automatic push_cmd(input logic w, input logic [6:0] a, input logic [7:0] d, output int pcyc);
      int waitc;
      waitc = 0;
      cmd_valid = 1'b1; cmd_write = w; cmd_adr = a; cmd_data = d;
      while (cmd_ready !== 1'b1 && waitc < 300) begin @(negedge reg_clk); waitc++; end
      if (cmd_ready !== 1'b1) begin
         checks++; failures++;
         $display("FAIL push_timeout cmd_ready=%b required=1", cmd_ready);
      end
      @(negedge reg_clk);
      pcyc = cyc;
      cmd_valid = 1'b0;
   endtask

   task automatic drain(output bit ok);
      int n;
      n = 0;
      while ((obs_bus.size() < exp_bus.size() || obs_rsp.size() < exp_rsp.size()) && n < 500) begin
         @(negedge reg_clk); n++;
      end
      ok = !(obs_bus.size() < exp_bus.size() || obs_rsp.size() < exp_rsp.size());
      repeat (8) @(negedge reg_clk);
   endtask

   task automatic test_reset();
      reset_reg = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_adr = 7'h16; cmd_data = 8'h55;
      repeat (2) begin
         @(negedge reg_clk);
         checks++;
         if ({write, read, read_select, osc_sel, rsp_valid, init_busy, cmd_ready} !== 7'b0) begin
            failures++;
            $display("FAIL reset_strobes got=%b required=0000000",
                     {write, read, read_select, osc_sel, rsp_valid, init_busy, cmd_ready});
         end
         checks++;
         if (adr !== 7'h00 || bus_wdata !== 8'h00 || rsp_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_data adr=%h wdata=%h rsp=%h required=0", adr, bus_wdata, rsp_data);
         end
      end
      clear_logs();
      reset_reg = 1'b0; cmd_valid = 1'b0;
      repeat (6) @(negedge reg_clk);
      checks++;
      if (obs_bus.size() != 0) begin
         failures++; $display("FAIL reset_bus_idle got=%0d transactions required=0", obs_bus.size());
      end
      checks++;
      if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_fifo_empty cmd_ready=%b required=1", cmd_ready); end
   endtask

   task automatic test_write_read();
      int pw, pr;
      bit ok;
      clear_logs();
      push_cmd(1'b1, 7'h16, 8'hA5, pw);
      model_write(7'h16, 8'hA5);
      drain(ok);
      checks++;
      if (!ok || obs_bus.size() != 1) begin failures++; $display("FAIL wr_count got=%0d required=1", obs_bus.size()); end
      checks++;
      if (obs_bus.size() < 1 || obs_bus[0] !== exp_bus[0]) begin
         failures++; $display("FAIL wr_txn got=%h required=%h", (obs_bus.size() > 0) ? obs_bus[0] : 16'hxxxx, exp_bus[0]);
      end
      checks++;
      if (last_wr_len != 1) begin failures++; $display("FAIL wr_pulse_len got=%0d required=1", last_wr_len); end
      checks++;
      if (obs_cyc.size() < 1 || obs_cyc[0] != pw + 2) begin
         failures++; $display("FAIL wr_latency got=%0d required=%0d", (obs_cyc.size() > 0) ? obs_cyc[0] : -1, pw + 2);
      end

      clear_logs();
      push_cmd(1'b0, 7'h16, 8'h00, pr);
      model_read(7'h16);
      drain(ok);
      checks++;
      if (!ok || obs_rsp.size() != 1) begin failures++; $display("FAIL rd_rsp_count got=%0d required=1", obs_rsp.size()); end
      checks++;
      if (obs_rsp.size() < 1 || obs_rsp[0] !== exp_rsp[0]) begin
         failures++; $display("FAIL rd_data got=%h required=%h", (obs_rsp.size() > 0) ? obs_rsp[0] : 8'hxx, exp_rsp[0]);
      end
      checks++;
      if (rsp_cyc.size() < 1 || rsp_cyc[0] != pr + 4) begin
         failures++; $display("FAIL rd_latency got=%0d required=%0d", (rsp_cyc.size() > 0) ? rsp_cyc[0] : -1, pr + 4);
      end
      checks++;
      if (last_rd_len != 2 || last_rsp_len != 1) begin
         failures++; $display("FAIL rd_pulse_len read=%0d rsp=%0d required=2/1", last_rd_len, last_rsp_len);
      end
      checks++;
      if (obs_bus.size() < 1 || obs_bus[0] !== exp_bus[0]) begin
         failures++; $display("FAIL rd_txn got=%h required=%h", (obs_bus.size() > 0) ? obs_bus[0] : 16'hxxxx, exp_bus[0]);
      end
   endtask

   task automatic test_init();
      int m, busy_cnt, first_busy;
      bit ok;
      clear_logs();
      init_value = 8'h7F; init_start = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_adr = 7'h25; cmd_data = 8'h3C;
      model_init(8'h7F);
      model_write(7'h25, 8'h3C);
      @(negedge reg_clk);
      m = cyc;
      init_start = 1'b0; cmd_valid = 1'b0; init_value = 8'($urandom);
      busy_cnt = 0; first_busy = -1;
      repeat (14) begin
         @(negedge reg_clk);
         if (init_busy === 1'b1) begin
            busy_cnt++;
            if (first_busy < 0) first_busy = cyc;
         end
      end
      drain(ok);
      checks++;
      if (busy_cnt != 2 * int'(V_OSC) || first_busy != m + 1) begin
         failures++; $display("FAIL init_busy cycles=%0d first=%0d required=%0d/%0d", busy_cnt, first_busy, 2 * V_OSC, m + 1);
      end
      checks++;
      if (!ok || obs_bus.size() != exp_bus.size()) begin
         failures++; $display("FAIL init_count got=%0d required=%0d", obs_bus.size(), exp_bus.size());
      end
      foreach (exp_bus[i]) begin
         checks++;
         if (i >= obs_bus.size() || obs_bus[i] !== exp_bus[i]) begin
            failures++; $display("FAIL init_txn[%0d] got=%h required=%h", i, (i < obs_bus.size()) ? obs_bus[i] : 16'hxxxx, exp_bus[i]);
         end
      end
      for (int k = 0; k < int'(V_OSC); k++) begin
         checks++;
         if (k >= obs_cyc.size() || obs_cyc[k] != m + 1 + 2 * k) begin
            failures++; $display("FAIL init_timing[%0d] got=%0d required=%0d", k, (k < obs_cyc.size()) ? obs_cyc[k] : -1, m + 1 + 2 * k);
         end
      end
   endtask

   task automatic test_back_to_back();
      int pc[6];
      logic [6:0] a;
      logic [7:0] d, v;
      bit ok;
      clear_logs();
      v = 8'($urandom);
      init_value = v; init_start = 1'b1;
      model_init(v);
      @(negedge reg_clk);
      init_start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         a = 7'($urandom); d = 8'($urandom);
         push_cmd(1'b1, a, d, pc[i]);
         model_write(a, d);
         if (i == 3) begin
            checks++;
            if (cmd_ready !== 1'b0 || pc[3] - pc[0] != 3) begin
               failures++; $display("FAIL bp_full cmd_ready=%b span=%0d required=0/3", cmd_ready, pc[3] - pc[0]);
            end
         end
      end
      drain(ok);
      checks++;
      if (!ok || obs_bus.size() != exp_bus.size()) begin
         failures++; $display("FAIL bp_count got=%0d required=%0d", obs_bus.size(), exp_bus.size());
      end
      foreach (exp_bus[i]) begin
         checks++;
         if (i >= obs_bus.size() || obs_bus[i] !== exp_bus[i]) begin
            failures++; $display("FAIL bp_txn[%0d] got=%h required=%h", i, (i < obs_bus.size()) ? obs_bus[i] : 16'hxxxx, exp_bus[i]);
         end
      end
      for (int k = int'(V_OSC) + 1; k < obs_cyc.size(); k++) begin
         checks++;
         if (obs_cyc[k] - obs_cyc[k-1] != 3) begin
            failures++; $display("FAIL bp_spacing[%0d] got=%0d required=3", k, obs_cyc[k] - obs_cyc[k-1]);
         end
      end
      checks++;
      if (gap_viol != 0) begin failures++; $display("FAIL bp_gap violations=%0d required=0", gap_viol); end
   endtask

   task automatic test_reset_mid_read();
      int p0, p1, p2;
      logic [6:0] ra, wa;
      logic [7:0] wd;
      bit ok;
      clear_logs();
      ra = 7'($urandom); wa = 7'($urandom);
      wd = shadow[wa] ^ 8'hFF;
      push_cmd(1'b0, ra, 8'h00, p0);
      exp_bus.push_back({1'b0, ra, 8'h00});
      push_cmd(1'b1, wa, wd, p1);
      push_cmd(1'b1, 7'($urandom), 8'($urandom), p2);
      checks++;
      if (read !== 1'b1 || cyc != p0 + 2) begin
         failures++; $display("FAIL mid_rd_active read=%b cyc=%0d required=1/%0d", read, cyc, p0 + 2);
      end
      reset_reg = 1'b1;
      @(negedge reg_clk);
      checks++;
      if ({write, read, read_select, osc_sel, cmd_ready} !== 5'b0) begin
         failures++; $display("FAIL mid_rd_strobes got=%b required=00000", {write, read, read_select, osc_sel, cmd_ready});
      end
      reset_reg = 1'b0;
      repeat (12) @(negedge reg_clk);
      checks++;
      if (obs_rsp.size() != 0) begin failures++; $display("FAIL mid_rd_no_rsp got=%0d required=0", obs_rsp.size()); end
      checks++;
      if (obs_bus.size() != 1 || obs_bus[0] !== exp_bus[0]) begin
         failures++; $display("FAIL mid_rd_flushed got=%0d transactions required=1", obs_bus.size());
      end
      checks++;
      if (cmd_ready !== 1'b1) begin failures++; $display("FAIL mid_rd_fifo_empty cmd_ready=%b required=1", cmd_ready); end
      clear_logs();
      push_cmd(1'b0, wa, 8'h00, p0);
      model_read(wa);
      drain(ok);
      checks++;
      if (!ok || obs_rsp.size() != 1 || obs_rsp[0] !== exp_rsp[0]) begin
         failures++; $display("FAIL mid_rd_discarded got=%h required=%h", (obs_rsp.size() > 0) ? obs_rsp[0] : 8'hxx, exp_rsp[0]);
      end
   endtask

   task automatic test_mixed();
      int p;
      logic       w;
      logic [2:0] o3;
      logic [6:0] a;
      logic [7:0] d;
      bit ok;
      clear_logs();
      for (int i = 0; i < 40; i++) begin
         w  = 1'($urandom_range(0, 1));
         o3 = 3'($urandom_range(0, 7));
         a  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : {o3, 4'h6};
         d  = 8'($urandom);
         push_cmd(w, a, d, p);
         if (w) model_write(a, d); else model_read(a);
         repeat ($urandom_range(0, 3)) @(negedge reg_clk);
      end
      drain(ok);
      checks++;
      if (!ok || obs_bus.size() != exp_bus.size() || obs_rsp.size() != exp_rsp.size()) begin
         failures++; $display("FAIL mixed_count bus=%0d rsp=%0d required=%0d/%0d",
                              obs_bus.size(), obs_rsp.size(), exp_bus.size(), exp_rsp.size());
      end
      foreach (exp_bus[i]) begin
         checks++;
         if (i >= obs_bus.size() || obs_bus[i] !== exp_bus[i]) begin
            failures++; $display("FAIL mixed_txn[%0d] got=%h required=%h", i, (i < obs_bus.size()) ? obs_bus[i] : 16'hxxxx, exp_bus[i]);
         end
      end
      foreach (exp_rsp[i]) begin
         checks++;
         if (i >= obs_rsp.size() || obs_rsp[i] !== exp_rsp[i]) begin
            failures++; $display("FAIL mixed_rsp[%0d] got=%h required=%h", i, (i < obs_rsp.size()) ? obs_rsp[i] : 8'hxx, exp_rsp[i]);
         end
      end
      checks++;
      if (gap_viol != 0 || strobe_bad != 0) begin
         failures++; $display("FAIL mixed_protocol gaps=%0d strobes=%0d required=0/0", gap_viol, strobe_bad);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_init();
      test_back_to_back();
      test_reset_mid_read();
      test_mixed();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d required=finish", cyc);
      $fatal(1, "watchdog");
   end

endmodule
